wd_fail_monitor_mc: RTL and testbench
=====================================

Name: wd_fail_monitor_mc

Overview:
- Multi-channel, fully synchronous successor to the single-channel watchdog fail detector. It checks the SWSTAT/WDSRVC service protocol per channel and adds a per-channel service timeout.
- Faults are sticky, carry a fault code, and stay latched until cleared per channel.
- Sits between the software-status/service sources and the system safety/reset controller. WDFAIL_ANY feeds the safety controller.

Parameters:
- NCH, 4, number of independent watchdog channels (1..16).
- TMO_W, 16, width of each channel's timeout counter.
- TMO_CYC, 1000, cycles allowed from arm (SWSTAT fall) to service (WDSRVC rise); must be in 1..2^TMO_W-1.

Ports:
- CLK  in  1  single clock; all inputs are pre-synchronised to CLK.
- RST  in  1  synchronous, active-high reset.
- CHEN  in  NCH  per-channel enable.
- SWSTAT  in  NCH  per-channel software status level.
- WDSRVC  in  NCH  per-channel service strobe; only the rising edge counts.
- FWOVR  in  1  firmware override; only the rising edge counts; applies to all channels.
- FLCLR  in  NCH  per-channel fault clear, level, one cycle is enough.
- WDFAIL  out  NCH  per-channel sticky fault flag.
- FLSTAT  out  3*NCH  per-channel fault code; channel i uses bits [3i+2:3i].
- WDFAIL_ANY  out  1  OR of WDFAIL.

Behaviour:
- Reset values: WDFAIL=0, FLSTAT=0, WDFAIL_ANY=0.
- Per-channel reset state: LMT=1, CNT=0, prev SWSTAT=0, prev WDSRVC=1, prev FWOVR=1. The prev values suppress spurious edges on the first cycle after reset; inputs already held high do not count as edges.
- Reset mid-operation discards all state, including latched faults.
- Edge detection: an edge exists in cycle k when input(k) differs from prev(k-1) in the relevant direction. Outputs update at the same clock edge, so latency is 1 cycle from input change to WDFAIL/FLSTAT.
- WDFAIL_ANY is registered alongside WDFAIL; no extra latency.
- Fault codes:
  - 000 FWOVR rising edge.
  - 001 WDSRVC rise while SWSTAT=0.
  - 010 WDSRVC rise while SWSTAT=1 and LMT=1 (double service).
  - 011 SWSTAT fall while LMT=0 (missed service).
  - 100 timeout.
- Per-channel protocol, only while CHEN[i]=1:
  - SWSTAT fall, LMT=1: LMT<=0, CNT<=0; the channel is now armed.
  - SWSTAT fall, LMT=0: fault 011.
  - WDSRVC rise, SWSTAT=0: fault 001. This includes the case where the SWSTAT fall happens in the same cycle; that case reports 001 and LMT is unchanged.
  - WDSRVC rise, SWSTAT=1, LMT=0: LMT<=1, CNT<=0; a good service.
  - WDSRVC rise, SWSTAT=1, LMT=1: fault 010.
- Timeout:
  - While armed (LMT=0), CNT increments by 1 per cycle and saturates at TMO_CYC.
  - When CNT reaches TMO_CYC-1 and no WDSRVC rise occurs that cycle, fault 100 is raised, CNT<=TMO_CYC, and the channel stays armed.
  - A service in that same cycle wins: no fault.
- Fault latching:
  - WDFAIL[i]<=1 and FLSTAT[i]<=code on the first fault only. Later faults leave FLSTAT unchanged while WDFAIL=1.
  - Protocol tracking (LMT, CNT) continues after a fault.
- Fault priority within one cycle: FWOVR (000) > 001 > 010 > 011 > 100.
- FWOVR rising edge raises fault 000 on every channel whose WDFAIL=0, including disabled channels.
- FLCLR[i]=1: WDFAIL[i]<=0, FLSTAT[i]<=000; LMT and CNT are not affected. If a fault is detected in the same cycle, the fault wins and latches its code.
- CHEN[i]=0: LMT held 1, CNT held 0, SWSTAT/WDSRVC edges ignored, prev registers still track. Re-enabling does not create edges. An existing fault is kept.
- Channels are fully independent apart from FWOVR and WDFAIL_ANY.

Test Plan:
- Reset, CHEN=4'hF, ch0 does SWSTAT 1->0 then after 10 cycles SWSTAT=1 and a WDSRVC pulse, repeated 3 times -> WDFAIL=0, FLSTAT=0 throughout.
- TMO_CYC=1000; ch1 SWSTAT falls at cycle 100 with no service -> WDFAIL[1] rises exactly 1000 cycles after the fall, FLSTAT[5:3]=100, WDFAIL_ANY=1. Second run with service in the deadline cycle -> no fault.
- ch2 gets two WDSRVC pulses with SWSTAT=1 and no SWSTAT fall in between -> FLSTAT[8:6]=010. Then FLCLR[2] pulse -> WDFAIL[2]=0 the next cycle. Then WDSRVC with SWSTAT=0 -> FLSTAT[8:6]=001.
- ch3 SWSTAT falls twice without service -> code 011. A FWOVR rise afterwards leaves ch3 at 011 and sets ch0..ch2 to 000.
- Simultaneous events: ch0 SWSTAT fall together with WDSRVC rise -> 001. FLCLR[0] together with a new fault -> WDFAIL[0] stays 1 with the new code. RST asserted mid-armed-count -> all outputs 0 and CNT restarts.
- CHEN[1]=0 with SWSTAT/WDSRVC toggling for 2000 cycles -> no fault; re-enable with inputs held high -> no spurious edge.

Source files
------------

// File: rtl/wd_fail_monitor_mc.sv
// ---------------------------------------------------------------------------
// wd_fail_monitor_mc
//
// Multi-channel watchdog fail monitor. Each channel checks the SWSTAT/WDSRVC
// service protocol and enforces a service deadline after being armed. Faults
// are sticky, carry a 3-bit code and stay latched until cleared per channel.
//
// Ports:
//   CLK          single clock; every input is already synchronised to it
//   RST          synchronous, active-high reset
//   CHEN[NCH]    per-channel enable
//   SWSTAT[NCH]  per-channel software status level (falling edge arms)
//   WDSRVC[NCH]  per-channel service strobe (rising edge counts)
//   FWOVR        firmware override, rising edge faults every clean channel
//   FLCLR[NCH]   per-channel fault clear (level)
//   WDFAIL[NCH]  per-channel sticky fault flag
//   FLSTAT[3*NCH] per-channel fault code, channel i at [3i+2:3i]
//   WDFAIL_ANY   OR of all WDFAIL bits, registered with them
//
// Fault codes: 000 FWOVR, 001 service while SWSTAT low, 010 double service,
//              011 missed service, 100 timeout.
// ---------------------------------------------------------------------------
module wd_fail_monitor_mc #(
   parameter int NCH     = 4,
   parameter int TMO_W   = 16,
   parameter int TMO_CYC = 1000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [NCH-1:0]   CHEN,
   input  logic [NCH-1:0]   SWSTAT,
   input  logic [NCH-1:0]   WDSRVC,
   input  logic             FWOVR,
   input  logic [NCH-1:0]   FLCLR,
   output logic [NCH-1:0]   WDFAIL,
   output logic [3*NCH-1:0] FLSTAT,
   output logic             WDFAIL_ANY
);

   typedef enum logic [2:0] {
      CODE_FWOVR    = 3'b000,
      CODE_SRVC_LOW = 3'b001,
      CODE_DOUBLE   = 3'b010,
      CODE_MISSED   = 3'b011,
      CODE_TIMEOUT  = 3'b100
   } fault_code_e;

   localparam logic [TMO_W-1:0] CNT_SAT  = TMO_W'(TMO_CYC);
   localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_CYC - 1);

   // Protocol state: LMT=1 means "serviced / not armed".
   logic [NCH-1:0]   lmt_q, lmt_d;
   logic [TMO_W-1:0] cnt_q [NCH];
   logic [TMO_W-1:0] cnt_d [NCH];

   // Previous input samples for edge detection.
   logic [NCH-1:0]   swstat_prev_q, swstat_prev_d;
   logic [NCH-1:0]   wdsrvc_prev_q, wdsrvc_prev_d;
   logic             fwovr_prev_q, fwovr_prev_d;

   // Registered outputs.
   logic [NCH-1:0]   wdfail_q, wdfail_d;
   logic [3*NCH-1:0] flstat_q, flstat_d;
   logic             wdfail_any_q, wdfail_any_d;

   // Per-cycle event decode.
   logic             fw_rise;
   logic [NCH-1:0]   sw_fall;
   logic [NCH-1:0]   sv_rise;
   logic [NCH-1:0]   fault_det;
   fault_code_e      fault_code [NCH];

   // Edge detection against the previous cycle's samples. The prev registers
   // keep tracking even for disabled channels so re-enabling cannot see a
   // stale edge.
   always_comb begin
      fw_rise       = FWOVR & ~fwovr_prev_q;
      sw_fall       = swstat_prev_q & ~SWSTAT;
      sv_rise       = WDSRVC & ~wdsrvc_prev_q;
      swstat_prev_d = SWSTAT;
      wdsrvc_prev_d = WDSRVC;
      fwovr_prev_d  = FWOVR;
   end

   // Fault detection with fixed priority FWOVR > 001 > 010 > 011 > 100.
   // FWOVR applies to disabled channels too; the protocol faults do not.
   // A service landing on the deadline cycle suppresses the timeout.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         fault_det[i]  = 1'b0;
         fault_code[i] = CODE_FWOVR;
         if (fw_rise) begin
            fault_det[i]  = 1'b1;
            fault_code[i] = CODE_FWOVR;
         end else if (CHEN[i] && sv_rise[i] && !SWSTAT[i]) begin
            fault_det[i]  = 1'b1;
            fault_code[i] = CODE_SRVC_LOW;
         end else if (CHEN[i] && sv_rise[i] && SWSTAT[i] && lmt_q[i]) begin
            fault_det[i]  = 1'b1;
            fault_code[i] = CODE_DOUBLE;
         end else if (CHEN[i] && sw_fall[i] && !lmt_q[i]) begin
            fault_det[i]  = 1'b1;
            fault_code[i] = CODE_MISSED;
         end else if (CHEN[i] && !lmt_q[i] && (cnt_q[i] == CNT_LAST) && !sv_rise[i]) begin
            fault_det[i]  = 1'b1;
            fault_code[i] = CODE_TIMEOUT;
         end
      end
   end

   // Protocol tracking. The counter runs only while armed and saturates at
   // TMO_CYC so a timed-out channel reports once. A service seen while
   // SWSTAT is low leaves LMT alone, even if SWSTAT fell in the same cycle.
   always_comb begin
      lmt_d = lmt_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!CHEN[i]) begin
            lmt_d[i] = 1'b1;
            cnt_d[i] = '0;
         end else begin
            if (!lmt_q[i] && (cnt_q[i] != CNT_SAT)) begin
               cnt_d[i] = cnt_q[i] + TMO_W'(1);
            end
            if (sv_rise[i]) begin
               if (SWSTAT[i] && !lmt_q[i]) begin
                  lmt_d[i] = 1'b1;
                  cnt_d[i] = '0;
               end
            end else if (sw_fall[i] && lmt_q[i]) begin
               lmt_d[i] = 1'b0;
               cnt_d[i] = '0;
            end
         end
      end
   end

   // Fault latching. Only the first fault sets the code; a clear in the same
   // cycle as a new fault loses, so the new code is latched.
   always_comb begin
      wdfail_d = wdfail_q;
      flstat_d = flstat_q;
      for (int i = 0; i < NCH; i++) begin
         if (FLCLR[i]) begin
            wdfail_d[i]        = 1'b0;
            flstat_d[3*i +: 3] = 3'b000;
         end
         if (fault_det[i] && (!wdfail_q[i] || FLCLR[i])) begin
            wdfail_d[i]        = 1'b1;
            flstat_d[3*i +: 3] = fault_code[i];
         end
      end
      wdfail_any_d = |wdfail_d;
   end

   // State registers. Reset preloads the prev registers so inputs already
   // high at release do not count as edges.
   always_ff @(posedge CLK) begin
      if (RST) begin
         lmt_q         <= '1;
         swstat_prev_q <= '0;
         wdsrvc_prev_q <= '1;
         fwovr_prev_q  <= 1'b1;
         wdfail_q      <= '0;
         flstat_q      <= '0;
         wdfail_any_q  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         lmt_q         <= lmt_d;
         swstat_prev_q <= swstat_prev_d;
         wdsrvc_prev_q <= wdsrvc_prev_d;
         fwovr_prev_q  <= fwovr_prev_d;
         wdfail_q      <= wdfail_d;
         flstat_q      <= flstat_d;
         wdfail_any_q  <= wdfail_any_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign WDFAIL     = wdfail_q;
   assign FLSTAT     = flstat_q;
   assign WDFAIL_ANY = wdfail_any_q;

endmodule

// File: tb/tb_wd_fail_monitor_mc.sv
// ---------------------------------------------------------------------------
// tb_wd_fail_monitor_mc
//
// Self-checking bench for wd_fail_monitor_mc (NCH=4, TMO_CYC=1000). Each
// driven cycle pushes its expected outputs to a scoreboard queue; the entry
// is popped and compared #1 after the following rising clock edge.
// ---------------------------------------------------------------------------
module tb_wd_fail_monitor_mc;

   localparam int NCH     = 4;
   localparam int TMO_W   = 16;
   localparam int TMO_CYC = 1000;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  CHEN;
   logic [3:0]  SWSTAT;
   logic [3:0]  WDSRVC;
   logic        FWOVR;
   logic [3:0]  FLCLR;
   logic [3:0]  WDFAIL;
   logic [11:0] FLSTAT;
   logic        WDFAIL_ANY;

   typedef struct {
      logic        rst;
      logic [3:0]  chen;
      logic [3:0]  sw;
      logic [3:0]  sv;
      logic [3:0]  fl;
      logic        fw;
      logic [3:0]  exp_fail;
      logic [11:0] exp_stat;
      string       name;
   } vec_t;

   typedef struct {
      logic [3:0]  fail;
      logic [11:0] stat;
      logic        any;
      string       name;
   } exp_t;

   vec_t tbl [$];
   exp_t sb  [$];
   int   assert_count = 0;
   int   fail_count   = 0;

   wd_fail_monitor_mc #(
      .NCH     (NCH),
      .TMO_W   (TMO_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CHEN       (CHEN),
      .SWSTAT     (SWSTAT),
      .WDSRVC     (WDSRVC),
      .FWOVR      (FWOVR),
      .FLCLR      (FLCLR),
      .WDFAIL     (WDFAIL),
      .FLSTAT     (FLSTAT),
      .WDFAIL_ANY (WDFAIL_ANY)
   );

   // 10-unit clock period.
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic rst, input logic [3:0] chen,
                               input logic [3:0] sw, input logic [3:0] sv,
                               input logic [3:0] fl, input logic fw,
                               input logic [3:0] ef, input logic [11:0] es,
                               input string nm);
      vec_t v;
      v.rst = rst; v.chen = chen; v.sw = sw; v.sv = sv; v.fl = fl; v.fw = fw;
      v.exp_fail = ef; v.exp_stat = es; v.name = nm;
      return v;
   endfunction

   // Pop the oldest expectation and compare it with the registered outputs.
   task automatic checkOutput();
      exp_t e;
      assert_count++;
      if (sb.size() == 0) begin
         fail_count++;
         $display("[TB] FAIL scoreboard_empty at %0t: no expectation queued", $time);
         return;
      end
      e = sb.pop_front();
      if (WDFAIL !== e.fail || FLSTAT !== e.stat || WDFAIL_ANY !== e.any) begin
         fail_count++;
         $display("[TB] FAIL %s at %0t: got WDFAIL=%h FLSTAT=%h ANY=%b, expected WDFAIL=%h FLSTAT=%h ANY=%b",
                  e.name, $time, WDFAIL, FLSTAT, WDFAIL_ANY, e.fail, e.stat, e.any);
      end
   endtask

   // Queue the expectation for the current inputs, clock once, then check.
   task automatic runCycle(input logic [3:0] ef, input logic [11:0] es, input string nm);
      exp_t e;
      e.fail = ef;
      e.stat = es;
      e.any  = |ef;
      e.name = nm;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input vec_t v);
      RST    = v.rst;
      CHEN   = v.chen;
      SWSTAT = v.sw;
      WDSRVC = v.sv;
      FLCLR  = v.fl;
      FWOVR  = v.fw;
      runCycle(v.exp_fail, v.exp_stat, v.name);
   endtask

   initial begin
      // Vector table: reset, three normal ch0 service rounds, ch2 faults.
      tbl.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 12'h000, "reset_0"));
      tbl.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 12'h000, "reset_1"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 12'h000, "sw_rise_no_event"));
      for (int r = 0; r < 3; r++) begin
         tbl.push_back(mk(0, 4'hF, 4'hE, 4'h0, 4'h0, 0, 4'h0, 12'h000, "ch0_arm"));
         for (int k = 0; k < 9; k++)
            tbl.push_back(mk(0, 4'hF, 4'hE, 4'h0, 4'h0, 0, 4'h0, 12'h000, "ch0_wait"));
         tbl.push_back(mk(0, 4'hF, 4'hF, 4'h1, 4'h0, 0, 4'h0, 12'h000, "ch0_service"));
         tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 12'h000, "ch0_idle"));
      end
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h4, 4'h0, 0, 4'h4, 12'h080, "ch2_double_first"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h4, 12'h080, "ch2_hold"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h4, 4'h0, 0, 4'h4, 12'h080, "ch2_double_sticky"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h4, 12'h080, "ch2_hold2"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 0, 4'h0, 12'h000, "ch2_clear"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 12'h000, "ch2_after_clear"));
      tbl.push_back(mk(0, 4'hF, 4'hB, 4'h0, 4'h0, 0, 4'h0, 12'h000, "ch2_arm"));
      tbl.push_back(mk(0, 4'hF, 4'hB, 4'h4, 4'h0, 0, 4'h4, 12'h040, "ch2_srvc_low"));
      tbl.push_back(mk(0, 4'hF, 4'hB, 4'h0, 4'h0, 0, 4'h4, 12'h040, "ch2_hold3"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h4, 12'h040, "ch2_sw_high"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h4, 4'h0, 0, 4'h4, 12'h040, "ch2_good_service"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h4, 12'h040, "ch2_hold4"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 0, 4'h0, 12'h000, "ch2_clear2"));
      tbl.push_back(mk(0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 4'h0, 12'h000, "ch2_idle"));

      $display("[TB] applying %0d table vectors", tbl.size());
      for (int n = 0; n < tbl.size(); n++)
         applyStimulus(tbl[n]);

      // ch1 timeout: the fault lands exactly TMO_CYC cycles after the fall.
      SWSTAT = 4'hD;
      runCycle(4'h0, 12'h000, "ch1_arm");
      for (int j = 1; j < TMO_CYC; j++)
         runCycle(4'h0, 12'h000, "ch1_counting");
      runCycle(4'h2, 12'h020, "ch1_timeout_exact");
      for (int j = 0; j < 3; j++)
         runCycle(4'h2, 12'h020, "ch1_timeout_sticky");
      SWSTAT = 4'hF; WDSRVC = 4'h2;
      runCycle(4'h2, 12'h020, "ch1_disarm");
      WDSRVC = 4'h0; FLCLR = 4'h2;
      runCycle(4'h0, 12'h000, "ch1_clear");
      FLCLR = 4'h0;

      // ch1 service on the deadline cycle wins over the timeout.
      SWSTAT = 4'hD;
      runCycle(4'h0, 12'h000, "ch1_arm2");
      for (int j = 1; j < TMO_CYC; j++)
         runCycle(4'h0, 12'h000, "ch1_counting2");
      SWSTAT = 4'hF; WDSRVC = 4'h2;
      runCycle(4'h0, 12'h000, "ch1_deadline_service");
      WDSRVC = 4'h0;
      for (int j = 0; j < 20; j++)
         runCycle(4'h0, 12'h000, "ch1_after_service");

      // ch3 missed service, then FWOVR hits only the clean channels.
      SWSTAT = 4'h7;
      runCycle(4'h0, 12'h000, "ch3_arm");
      SWSTAT = 4'hF;
      runCycle(4'h0, 12'h000, "ch3_sw_high");
      SWSTAT = 4'h7;
      runCycle(4'h8, 12'h600, "ch3_missed");
      SWSTAT = 4'hF;
      runCycle(4'h8, 12'h600, "ch3_hold");
      FWOVR = 1'b1;
      runCycle(4'hF, 12'h600, "fwovr_all");
      runCycle(4'hF, 12'h600, "fwovr_held_no_edge");
      FWOVR = 1'b0; WDSRVC = 4'h8;
      runCycle(4'hF, 12'h600, "ch3_disarm");
      WDSRVC = 4'h0; FLCLR = 4'hF;
      runCycle(4'h0, 12'h000, "clear_all");
      FLCLR = 4'h0;
      runCycle(4'h0, 12'h000, "idle_after_clear");

      // Simultaneous fall + service reports 001 and leaves ch0 disarmed, so
      // the next high-status service is a double service that beats FLCLR.
      SWSTAT = 4'hE; WDSRVC = 4'h1;
      runCycle(4'h1, 12'h001, "ch0_fall_and_srvc");
      WDSRVC = 4'h0;
      runCycle(4'h1, 12'h001, "ch0_hold");
      SWSTAT = 4'hF;
      runCycle(4'h1, 12'h001, "ch0_sw_high");
      WDSRVC = 4'h1; FLCLR = 4'h1;
      runCycle(4'h1, 12'h002, "ch0_clear_vs_fault");
      WDSRVC = 4'h0; FLCLR = 4'h0;
      runCycle(4'h1, 12'h002, "ch0_hold2");

      // Reset in the middle of an armed count discards everything.
      SWSTAT = 4'hD;
      runCycle(4'h1, 12'h002, "ch1_arm3");
      for (int j = 0; j < 500; j++)
         runCycle(4'h1, 12'h002, "ch1_mid_count");
      RST = 1'b1;
      runCycle(4'h0, 12'h000, "mid_reset");
      RST = 1'b0;
      runCycle(4'h0, 12'h000, "post_reset_low_no_edge");
      SWSTAT = 4'hF;
      runCycle(4'h0, 12'h000, "ch1_sw_high");
      SWSTAT = 4'hD;
      runCycle(4'h0, 12'h000, "ch1_rearm");
      for (int j = 1; j < TMO_CYC; j++)
         runCycle(4'h0, 12'h000, "ch1_restart_count");
      runCycle(4'h2, 12'h020, "ch1_restart_timeout");
      SWSTAT = 4'hF; WDSRVC = 4'h2;
      runCycle(4'h2, 12'h020, "ch1_disarm3");
      WDSRVC = 4'h0; FLCLR = 4'h2;
      runCycle(4'h0, 12'h000, "ch1_clear3");
      FLCLR = 4'h0;

      // Disabled ch1 ignores its protocol inputs entirely.
      CHEN = 4'hD;
      for (int j = 0; j < 2000; j++) begin
         SWSTAT[1] = j[1];
         WDSRVC[1] = j[0];
         runCycle(4'h0, 12'h000, "ch1_disabled_toggle");
      end
      SWSTAT = 4'hF; WDSRVC = 4'h2;
      runCycle(4'h0, 12'h000, "ch1_hold_high");
      CHEN = 4'hF;
      for (int j = 0; j < 5; j++)
         runCycle(4'h0, 12'h000, "ch1_reenable_no_edge");
      WDSRVC = 4'h0;
      runCycle(4'h0, 12'h000, "ch1_srvc_drop");
      WDSRVC = 4'h2;
      runCycle(4'h2, 12'h010, "ch1_double_after_reenable");

      // FWOVR still faults disabled channels; ch1 keeps its earlier code.
      CHEN = 4'h0; WDSRVC = 4'h0; FWOVR = 1'b1;
      runCycle(4'hF, 12'h010, "fwovr_disabled_channels");
      FWOVR = 1'b0;
      runCycle(4'hF, 12'h010, "final_hold");

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
